// File: rtl/dice_pkg.sv
// Shared types and craps-rule constants for the dice game controller.
package dice_pkg;

  typedef enum logic [1:0] {
    COME_OUT = 2'd0,
    POINT    = 2'd1,
    WIN      = 2'd2,
    LOSE     = 2'd3
  } game_state_t;

  localparam logic [3:0] SUM_MIN      = 4'd2;
  localparam logic [3:0] SUM_MAX      = 4'd12;
  localparam logic [3:0] SUM_SEVEN    = 4'd7;
  localparam logic [3:0] SUM_ELEVEN   = 4'd11;
  localparam logic [3:0] CRAPS_TWO    = 4'd2;
  localparam logic [3:0] CRAPS_THREE  = 4'd3;
  localparam logic [3:0] CRAPS_TWELVE = 4'd12;

  function automatic logic sum_valid(input logic [3:0] s);
    return (s >= SUM_MIN) && (s <= SUM_MAX);
  endfunction

  // Outcome of a first roll; also used when a finished game restarts.
  function automatic game_state_t come_out_result(input logic [3:0] s);
    game_state_t r;
    if ((s == SUM_SEVEN) || (s == SUM_ELEVEN)) begin
      r = WIN;
    end else if ((s == CRAPS_TWO) || (s == CRAPS_THREE) || (s == CRAPS_TWELVE)) begin
      r = LOSE;
    end else begin
      r = POINT;
    end
    return r;
  endfunction

endpackage

// File: rtl/dice_game_ctrl_if.sv
// Signal bundle between the player/counter side and the dice game controller.
interface dice_game_ctrl_if
  import dice_pkg::*;
#(
  parameter int ROLL_CNT_W = 8
);
  // No valid/ready pair here: result_valid is a single-cycle strobe with no
  // backpressure, and the other outputs are levels that hold between rolls.
  logic                  roll_btn;
  logic [3:0]            sum;
  logic                  dice_en;
  logic [3:0]            last_sum;
  logic [3:0]            point;
  logic                  win;
  logic                  lose;
  logic                  result_valid;
  logic [ROLL_CNT_W-1:0] roll_cnt;
  game_state_t           state;

  modport master (
    output roll_btn, sum,
    input  dice_en, last_sum, point, win, lose, result_valid, roll_cnt, state
  );

  modport slave (
    input  roll_btn, sum,
    output dice_en, last_sum, point, win, lose, result_valid, roll_cnt, state
  );

endinterface

// File: rtl/dice_game_ctrl_button_debounce.sv
// Level debouncer: dout follows din only after DEBOUNCE_CYCLES consecutive
// mismatching samples; any shorter glitch is discarded.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din != dout) begin
      if (cnt == CNT_LAST) begin
        dout <= din;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/dice_game_ctrl.sv
// Craps game controller: debounces the roll button, drives the dice counter
// enable, and evaluates the dice sum when the button is released.
module dice_game_ctrl
  import dice_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ROLL_CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  dice_game_ctrl_if.slave   bus
);

  logic                  roll_db;
  logic                  roll_db_d;
  logic                  rel;
  logic                  accept;
  game_state_t           state;
  game_state_t           next_state;
  logic [3:0]            last_sum_q;
  logic [3:0]            point_q;
  logic                  win_q;
  logic                  lose_q;
  logic                  result_valid_q;
  logic [ROLL_CNT_W-1:0] roll_cnt_q;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_roll_debounce (
    .clk   (clk),
    .reset (reset),
    .din   (bus.roll_btn),
    .dout  (roll_db)
  );

  // By the time rel is seen the counter has been disabled for a cycle, so sum is settled.
  assign rel    = roll_db_d & ~roll_db;
  assign accept = rel & sum_valid(bus.sum);

  always_comb begin
    next_state = state;
    case (state)
      COME_OUT: next_state = come_out_result(bus.sum);
      POINT: begin
        if (bus.sum == point_q) begin
          next_state = WIN;
        end else if (bus.sum == SUM_SEVEN) begin
          next_state = LOSE;
        end else begin
          next_state = POINT;
        end
      end
      WIN, LOSE: next_state = come_out_result(bus.sum);
      default:   next_state = COME_OUT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      roll_db_d      <= 1'b0;
      state          <= COME_OUT;
      last_sum_q     <= '0;
      point_q        <= '0;
      win_q          <= 1'b0;
      lose_q         <= 1'b0;
      result_valid_q <= 1'b0;
      roll_cnt_q     <= '0;
    end else begin
      roll_db_d      <= roll_db;
      result_valid_q <= 1'b0;
      if (accept) begin
        result_valid_q <= 1'b1;
        last_sum_q     <= bus.sum;
        state          <= next_state;
        win_q          <= (next_state == WIN);
        lose_q         <= (next_state == LOSE);
        if ((state == WIN) || (state == LOSE)) begin
          roll_cnt_q <= ROLL_CNT_W'(1);
        end else if (roll_cnt_q != '1) begin
          roll_cnt_q <= roll_cnt_q + 1'b1;
        end
        // Point is only (re)loaded when leaving a come-out roll; a point
        // win/loss keeps it visible until the next game starts.
        if (state != POINT) begin
          point_q <= (next_state == POINT) ? bus.sum : 4'd0;
        end
      end
    end
  end

  assign bus.dice_en      = roll_db;
  assign bus.last_sum     = last_sum_q;
  assign bus.point        = point_q;
  assign bus.win          = win_q;
  assign bus.lose         = lose_q;
  assign bus.result_valid = result_valid_q;
  assign bus.roll_cnt     = roll_cnt_q;
  assign bus.state        = state;

endmodule

// File: tb/tb_dice_game_ctrl.sv
// Directed + randomized bench for dice_game_ctrl against a craps-rules model.
module tb_dice_game_ctrl;
  import dice_pkg::*;

  localparam int DEB    = 4;
  localparam int CNT_W  = 3;
  localparam int CNT_MX = (1 << CNT_W) - 1;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  // Scoreboard entry: {win, lose, point[3:0], last_sum[3:0], roll_cnt[7:0]}
  logic [17:0] exp_q[$];

  // Model of the game as the player sees it
  int m_point, m_outcome, m_cnt, m_last;  // m_outcome: 0 playing, 1 won, 2 lost

  dice_game_ctrl_if #(.ROLL_CNT_W(CNT_W)) bus ();

  dice_game_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .ROLL_CNT_W      (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_point = 0; m_outcome = 0; m_cnt = 0; m_last = 0;
  endtask

  // Applies craps rules to one released roll; returns 1 if the roll counts.
  function automatic bit model_roll(input int s);
    if (s < 2 || s > 12) return 0;
    if (m_outcome != 0) begin
      m_outcome = 0; m_point = 0; m_cnt = 1;
    end else begin
      m_cnt = (m_cnt < CNT_MX) ? m_cnt + 1 : CNT_MX;
    end
    m_last = s;
    if (m_point == 0) begin
      if (s == 7 || s == 11) m_outcome = 1;
      else if (s == 2 || s == 3 || s == 12) m_outcome = 2;
      else m_point = s;
    end else begin
      if (s == m_point) m_outcome = 1;
      else if (s == 7) m_outcome = 2;
    end
    exp_q.push_back({m_outcome == 1, m_outcome == 2, 4'(m_point), 4'(m_last), 8'(m_cnt)});
    return 1;
  endfunction

  task automatic check_levels(input string tag);
    check({tag, ".win"},      32'(bus.win),      32'(m_outcome == 1));
    check({tag, ".lose"},     32'(bus.lose),     32'(m_outcome == 2));
    check({tag, ".point"},    32'(bus.point),    32'(m_point));
    check({tag, ".last_sum"}, 32'(bus.last_sum), 32'(m_last));
    check({tag, ".roll_cnt"}, 32'(bus.roll_cnt), 32'(m_cnt));
  endtask

  // Press for hold cycles with the counter spinning, release on sum s, then
  // watch a bounded window for the evaluation strobe.
  task automatic do_roll(input logic [3:0] s, input int hold, input string tag);
    bit          acc;
    int          pulses;
    logic [17:0] e;
    logic [17:0] got;
    bus.roll_btn = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.sum = 4'($urandom_range(0, 15));
    end
    check({tag, ".dice_en_hi"}, 32'(bus.dice_en), 32'd1);
    bus.roll_btn = 1'b0;
    bus.sum      = s;
    acc    = model_roll(int'(s));
    pulses = 0;
    got    = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.result_valid === 1'b1) begin
        pulses++;
        got = {bus.win, bus.lose, bus.point, bus.last_sum, 8'(bus.roll_cnt)};
      end
    end
    check({tag, ".pulses"}, 32'(pulses), acc ? 32'd1 : 32'd0);
    check({tag, ".dice_en_lo"}, 32'(bus.dice_en), 32'd0);
    if (acc && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, ".rv_snapshot"}, 32'(got), 32'(e));
    end
    check_levels(tag);
  endtask

  initial begin
    int glitch_lens[3];
    int sat_seq[10];
    int pulses;
    int en_seen;
    glitch_lens = '{1, 2, 3};
    sat_seq     = '{4, 5, 6, 8, 9, 10, 3, 2, 12, 11};

    // Reset held for three cycles, then twenty idle cycles
    reset = 1'b0; bus.roll_btn = 1'b0; bus.sum = 4'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset.dice_en", 32'(bus.dice_en), 32'd0);
    check("reset.rv", 32'(bus.result_valid), 32'd0);
    check("reset.state", 32'(bus.state), 32'(COME_OUT));
    check_levels("reset");
    reset = 1'b1;
    pulses = 0; en_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.sum = 4'($urandom_range(0, 15));
      if (bus.result_valid === 1'b1) pulses++;
      if (bus.dice_en === 1'b1) en_seen++;
    end
    check("idle.rv", 32'(pulses), 32'd0);
    check("idle.dice_en", 32'(en_seen), 32'd0);
    check_levels("idle");

    // Presses shorter than the debounce window
    foreach (glitch_lens[g]) begin
      bus.roll_btn = 1'b1;
      repeat (glitch_lens[g]) @(negedge clk);
      bus.roll_btn = 1'b0;
      pulses = 0; en_seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (bus.result_valid === 1'b1) pulses++;
        if (bus.dice_en === 1'b1) en_seen++;
      end
      check($sformatf("glitch%0d.dice_en", glitch_lens[g]), 32'(en_seen), 32'd0);
      check($sformatf("glitch%0d.rv", glitch_lens[g]), 32'(pulses), 32'd0);
    end

    // Natural, point won, point lost, new game straight to craps
    do_roll(4'd7, 6, "natural7");
    do_roll(4'd6, 5, "comeout6");
    check("comeout6.state", 32'(bus.state), 32'(POINT));
    do_roll(4'd8, 7, "point6_roll8");
    do_roll(4'd6, 6, "point6_hit");
    do_roll(4'd9, 6, "comeout9");
    do_roll(4'd7, 8, "point9_seven");
    do_roll(4'd2, 6, "newgame2");

    // Out-of-range sums are ignored
    do_roll(4'd0, 6, "sum0");
    do_roll(4'd13, 6, "sum13");
    do_roll(4'd1, 6, "sum1");

    // Long point game to saturate the roll counter
    foreach (sat_seq[k]) do_roll(4'(sat_seq[k]), 5, $sformatf("sat%0d", k));
    check("sat.roll_cnt", 32'(bus.roll_cnt), 32'(CNT_MX));
    do_roll(4'd4, 5, "sat_hit");

    // Reset while the button is held aborts the roll
    bus.roll_btn = 1'b1;
    repeat (7) @(negedge clk);
    check("midreset.dice_en_hi", 32'(bus.dice_en), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    model_reset();
    check("midreset.dice_en_lo", 32'(bus.dice_en), 32'd0);
    check_levels("midreset");
    reset = 1'b1;
    bus.roll_btn = 1'b0;
    bus.sum = 4'd7;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.result_valid === 1'b1) pulses++;
    end
    check("midreset.rv", 32'(pulses), 32'd0);
    check_levels("post_reset");

    // Random games
    for (int r = 0; r < 40; r++) begin
      do_roll(4'($urandom_range(0, 15)), int'($urandom_range(5, 10)), $sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
